// File: rtl/qdr_word_align_pkg.sv
// Shared types and constants for the QDR word aligner: FSM encoding, sample slot
// ordering within a raw capture word, and a saturating counter helper.
package qdr_word_align_pkg;

   typedef enum logic [1:0] {
      SEARCH      = 2'd0,
      SETTLE_WAIT = 2'd1,
      LOCKED      = 2'd2
   } state_e;

   // Slot index of each capture phase inside the raw word (slot 0 = LSBs, oldest)
   localparam int unsigned RISE0  = 0;
   localparam int unsigned RISE90 = 1;
   localparam int unsigned FALL0  = 2;
   localparam int unsigned FALL90 = 3;

   localparam int unsigned SLOTS = 4;
   localparam int unsigned CNT_W = 8;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/qdr_slip_mux.sv
// Registered 8-to-4 sample selector: picks four consecutive samples starting at
// slot i_slip out of the window {current raw word, previous raw word}.
module qdr_slip_mux
   import qdr_word_align_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_0,
   input  logic                     rst_n,
   input  logic [SLOTS*WIDTH-1:0]   i_raw,
   input  logic [SLOTS*WIDTH-1:0]   i_raw_prev,
   input  logic [1:0]               i_slip,
   output logic [SLOTS*WIDTH-1:0]   o_data
);

   logic [2*SLOTS*WIDTH-1:0] w_window;
   logic [SLOTS*WIDTH-1:0]   w_sel;
   logic [SLOTS*WIDTH-1:0]   r_data;

   // Previous word occupies the low half, so slip 0 is the older word verbatim
   assign w_window = {i_raw, i_raw_prev};

   always_comb begin
      w_sel = '0;
      unique case (i_slip)
         2'd0: w_sel = w_window[0*WIDTH +: SLOTS*WIDTH];
         2'd1: w_sel = w_window[1*WIDTH +: SLOTS*WIDTH];
         2'd2: w_sel = w_window[2*WIDTH +: SLOTS*WIDTH];
         2'd3: w_sel = w_window[3*WIDTH +: SLOTS*WIDTH];
         default: w_sel = '0;
      endcase
   end

   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else begin
         r_data <= w_sel;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/qdr_word_align.sv
// QDR word aligner: orders the four phase samples into time order, then searches
// slip 0..3 against a training word and holds lock until repeated misses.
module qdr_word_align
   import qdr_word_align_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned LOCK_COUNT = 16,
   parameter int unsigned SETTLE     = 2,
   parameter int unsigned LOSS_COUNT = 4
) (
   input  logic                   clk_0,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       data_rise_0,
   input  logic [WIDTH-1:0]       data_rise_90,
   input  logic [WIDTH-1:0]       data_fall_0,
   input  logic [WIDTH-1:0]       data_fall_90,
   input  logic                   train_en,
   input  logic [4*WIDTH-1:0]     train_word,
   input  logic                   realign,
   output logic [4*WIDTH-1:0]     data_out,
   output logic                   data_valid,
   output logic                   locked,
   output logic [1:0]             slip
);

   localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_COUNT - 1);
   localparam logic [CNT_W-1:0] LossLast   = CNT_W'(LOSS_COUNT - 1);
   localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE - 1);

   logic [SLOTS*WIDTH-1:0] w_raw;
   logic [SLOTS*WIDTH-1:0] r_raw;
   logic [SLOTS*WIDTH-1:0] r_raw_prev;

   state_e                 r_state, w_state;
   logic [CNT_W-1:0]       r_match_cnt, w_match_cnt;
   logic [CNT_W-1:0]       r_miss_cnt, w_miss_cnt;
   logic [CNT_W-1:0]       r_settle_cnt, w_settle_cnt;
   logic [1:0]             r_slip, w_slip;
   logic                   r_locked, w_locked;
   logic                   r_valid;
   logic                   w_match;

   always_comb begin
      w_raw = '0;
      w_raw[RISE0*WIDTH  +: WIDTH] = data_rise_0;
      w_raw[RISE90*WIDTH +: WIDTH] = data_rise_90;
      w_raw[FALL0*WIDTH  +: WIDTH] = data_fall_0;
      w_raw[FALL90*WIDTH +: WIDTH] = data_fall_90;
   end

   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         r_raw      <= '0;
         r_raw_prev <= '0;
      end else begin
         r_raw      <= w_raw;
         r_raw_prev <= r_raw;
      end
   end

   qdr_slip_mux #(
      .WIDTH(WIDTH)
   ) u_slip_mux (
      .clk_0      (clk_0),
      .rst_n      (rst_n),
      .i_raw      (r_raw),
      .i_raw_prev (r_raw_prev),
      .i_slip     (r_slip),
      .o_data     (data_out)
   );

   assign w_match = (data_out == train_word);

   always_comb begin
      w_state      = r_state;
      w_match_cnt  = r_match_cnt;
      w_miss_cnt   = r_miss_cnt;
      w_settle_cnt = r_settle_cnt;
      w_slip       = r_slip;
      w_locked     = r_locked;
      if (realign) begin
         w_state      = SEARCH;
         w_match_cnt  = '0;
         w_miss_cnt   = '0;
         w_settle_cnt = '0;
         w_locked     = 1'b0;
      end else begin
         unique case (r_state)
            SEARCH: begin
               if (train_en) begin
                  if (w_match) begin
                     if (r_match_cnt >= LockLast) begin
                        w_state     = LOCKED;
                        w_locked    = 1'b1;
                        w_match_cnt = '0;
                        w_miss_cnt  = '0;
                     end else begin
                        w_match_cnt = sat_inc(r_match_cnt);
                     end
                  end else begin
                     w_match_cnt  = '0;
                     w_settle_cnt = '0;
                     w_slip       = r_slip + 2'd1;
                     w_state      = SETTLE_WAIT;
                  end
               end
            end
            SETTLE_WAIT: begin
               // Wait for the selector pipeline to refill with the new slip
               if (r_settle_cnt >= SettleLast) begin
                  w_state      = SEARCH;
                  w_settle_cnt = '0;
                  w_match_cnt  = '0;
               end else begin
                  w_settle_cnt = sat_inc(r_settle_cnt);
               end
            end
            LOCKED: begin
               if (train_en) begin
                  if (w_match) begin
                     w_miss_cnt = '0;
                  end else if (r_miss_cnt >= LossLast) begin
                     w_state    = SEARCH;
                     w_locked   = 1'b0;
                     w_miss_cnt = '0;
                  end else begin
                     w_miss_cnt = sat_inc(r_miss_cnt);
                  end
               end
            end
            default: begin
               w_state  = SEARCH;
               w_locked = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= SEARCH;
         r_match_cnt  <= '0;
         r_miss_cnt   <= '0;
         r_settle_cnt <= '0;
         r_slip       <= '0;
         r_locked     <= 1'b0;
         r_valid      <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_match_cnt  <= w_match_cnt;
         r_miss_cnt   <= w_miss_cnt;
         r_settle_cnt <= w_settle_cnt;
         r_slip       <= w_slip;
         r_locked     <= w_locked;
         r_valid      <= (w_state == LOCKED);
      end
   end

   assign data_valid = r_valid;
   assign locked     = r_locked;
   assign slip       = r_slip;

endmodule
